b16_to_bcd: RTL and testbench



---
 rtl/b16_to_bcd_if.sv | 15 +
 rtl/b16_to_bcd.sv | 70 +++++++
 tb/tb_b16_to_bcd.sv | 134 +++++++++++++
 3 files changed

// File: rtl/b16_to_bcd_if.sv
// Conversion bus for b16_to_bcd: binary value and enable in, five BCD digits out.
interface b16_to_bcd_if;
  logic [15:0] to_display;
  logic        enable;
  logic [3:0]  D5;
  logic [3:0]  D4;
  logic [3:0]  D3;
  logic [3:0]  D2;
  logic [3:0]  D1;

  modport master (output to_display, output enable,
                  input D5, input D4, input D3, input D2, input D1);
  modport slave  (input to_display, input enable,
                  output D5, output D4, output D3, output D2, output D1);
endinterface

// File: rtl/b16_to_bcd.sv
// 16-bit binary to five-digit BCD, combinational double-dabble into registered digits.
// Optional leading-zero blanking (digit 4'hF) when B16_TO_BCD_BLANK_EN is defined.
module b16_to_bcd (
  input logic        clk,
  input logic        rst_n,
  b16_to_bcd_if.slave bus
);

  logic [19:0] bcd_raw;
  logic [15:0] bin_sh;
  logic [19:0] digits_d;
  logic [19:0] digits_q;

  function automatic logic [3:0] add3(input logic [3:0] nib);
    add3 = (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  always_comb begin
    bcd_raw = '0;
    bin_sh  = bus.to_display;
    for (int i = 0; i < 16; i++) begin
      bcd_raw = {add3(bcd_raw[19:16]), add3(bcd_raw[15:12]), add3(bcd_raw[11:8]),
                 add3(bcd_raw[7:4]), add3(bcd_raw[3:0])};
      bcd_raw = {bcd_raw[18:0], bin_sh[15]};
      bin_sh  = {bin_sh[14:0], 1'b0};
    end
  end

`ifdef B16_TO_BCD_BLANK_EN
  logic blank5, blank4, blank3, blank2;

  // Blanking propagates from the top digit and stops at the first nonzero one.
  always_comb begin
    blank5 = (bcd_raw[19:16] == 4'd0);
    blank4 = blank5 && (bcd_raw[15:12] == 4'd0);
    blank3 = blank4 && (bcd_raw[11:8] == 4'd0);
    blank2 = blank3 && (bcd_raw[7:4] == 4'd0);
    digits_d = 20'hFFFFF;
    if (bus.enable) begin
      digits_d = {blank5 ? 4'hF : bcd_raw[19:16],
                  blank4 ? 4'hF : bcd_raw[15:12],
                  blank3 ? 4'hF : bcd_raw[11:8],
                  blank2 ? 4'hF : bcd_raw[7:4],
                  bcd_raw[3:0]};
    end
  end
`else
  always_comb begin
    digits_d = '0;
    if (bus.enable) begin
      digits_d = bcd_raw;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
    end else begin
      digits_q <= digits_d;
    end
  end

  assign bus.D5 = digits_q[19:16];
  assign bus.D4 = digits_q[15:12];
  assign bus.D3 = digits_q[11:8];
  assign bus.D2 = digits_q[7:4];
  assign bus.D1 = digits_q[3:0];

endmodule

// File: tb/tb_b16_to_bcd.sv
// Self-checking bench for b16_to_bcd: directed steps plus a random stream, scoreboard queue.
module tb_b16_to_bcd;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [19:0] exp_q[$];

  b16_to_bcd_if bus ();

  b16_to_bcd dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [19:0] model(input logic [15:0] v, input logic en);
    logic [3:0] d5, d4, d3, d2, d1;
    int unsigned x;
    x  = v;
    d5 = 4'(x / 10000);
    d4 = 4'((x / 1000) % 10);
    d3 = 4'((x / 100) % 10);
    d2 = 4'((x / 10) % 10);
    d1 = 4'(x % 10);
`ifdef B16_TO_BCD_BLANK_EN
    if (!en) return 20'hFFFFF;
    if (d5 == 0) begin
      d5 = 4'hF;
      if (d4 == 0) begin
        d4 = 4'hF;
        if (d3 == 0) begin
          d3 = 4'hF;
          if (d2 == 0) d2 = 4'hF;
        end
      end
    end
`else
    if (!en) return 20'h00000;
`endif
    return {d5, d4, d3, d2, d1};
  endfunction

  function automatic logic [19:0] observed();
    return {bus.D5, bus.D4, bus.D3, bus.D2, bus.D1};
  endfunction

  task automatic check(input string tag, input logic [19:0] exp);
    logic [19:0] obs;
    obs = observed();
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one value away from the edge, let one edge sample it, then compare.
  task automatic step(input string tag, input logic [15:0] v, input logic en);
    logic [19:0] exp;
    @(negedge clk);
    bus.to_display = v;
    bus.enable     = en;
    exp_q.push_back(model(v, en));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      exp = exp_q.pop_front();
      check(tag, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    rst_n          = 1'b0;
    bus.to_display = 16'd12345;
    bus.enable     = 1'b1;
    #2;
    check("reset_no_clock", 20'h00000);

    @(negedge clk);
    rst_n = 1'b1;
    step("after_reset_12345", 16'd12345, 1'b1);

    step("max_65535", 16'd65535, 1'b1);
    step("zero", 16'd0, 1'b1);
    step("disabled_9999", 16'd9999, 1'b0);
    step("enabled_9999", 16'd9999, 1'b1);
    step("ten_thousand", 16'd10000, 1'b1);
    step("small_42", 16'd42, 1'b1);
    step("tens_90", 16'd90, 1'b1);
    step("hundreds_305", 16'd305, 1'b1);
    step("thousands_1009", 16'd1009, 1'b1);
    step("dabble_5959", 16'd5959, 1'b1);

    // Async reset between edges must clear held digits before the next edge.
    step("hold_65535", 16'd65535, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midcycle_reset", 20'h00000);
    @(negedge clk);
    check("reset_held_over_edge", 20'h00000);
    rst_n = 1'b1;
    step("resume_after_reset", 16'd4321, 1'b1);

    for (int k = 0; k < 100; k++) begin
      step("random_stream", 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
    end

    step("final_disabled", 16'd777, 1'b0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
